// File: rtl/pipeline_latealu_if.sv
// Late-op request bundle from the ALU stage into the late-ALU stage.
interface pipeline_latealu_if;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0;
    logic [31:0] latealu_a1;
    logic [2:0]  exception_in;
    logic [31:0] exception_pc;

    modport master (
        output latealu_enable, latealu_op, latealu_a0, latealu_a1,
               exception_in, exception_pc
    );
    modport slave (
        input  latealu_enable, latealu_op, latealu_a0, latealu_a1,
               exception_in, exception_pc
    );
endinterface

// File: rtl/pipeline_latealu.sv
// Late-ALU stage: HI/LO multiplier state plus CP0 Status/Cause/EPC.
// Define LATEALU_FAST_MULT_EN for a single-cycle multiply instead of the iterative FSM.
module pipeline_latealu #(
    parameter int unsigned MULT_BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_latealu_if.slave   bus,
    output logic [31:0]         latealu_mult_hi,
    output logic [31:0]         latealu_mult_lo,
    output logic [31:0]         latealu_cpr14,
    output logic                mult_busy,
    output logic                mfc0_valid,
    output logic [31:0]         mfc0_value,
    output logic                exc_pending
);
    localparam logic [5:0] OP_MULT    = 6'b000100;
    localparam logic [5:0] OP_MTHI    = 6'b000101;
    localparam logic [5:0] OP_MTLO    = 6'b000110;
    localparam logic [5:0] OP_SYSCALL = 6'b001000;
    localparam logic [5:0] OP_ERET    = 6'b001001;
    localparam logic [5:0] OP_MFC0    = 6'b001010;
    localparam logic [5:0] OP_MTC0    = 6'b001011;

    logic [31:0] r_hi, r_lo, r_status, r_cause, r_epc;
    logic        w_is_mult, w_is_mthi, w_is_mtlo, w_is_syscall, w_is_eret, w_is_mfc0, w_is_mtc0;
    logic [4:0]  w_cp0_idx;
    logic [31:0] w_cp0_rd;
    logic        w_hilo_wr;
    logic [63:0] w_hilo_val;

    assign w_is_mult    = bus.latealu_enable && (bus.latealu_op == OP_MULT);
    assign w_is_mthi    = bus.latealu_enable && (bus.latealu_op == OP_MTHI);
    assign w_is_mtlo    = bus.latealu_enable && (bus.latealu_op == OP_MTLO);
    assign w_is_syscall = bus.latealu_enable && (bus.latealu_op == OP_SYSCALL);
    assign w_is_eret    = bus.latealu_enable && (bus.latealu_op == OP_ERET);
    assign w_is_mfc0    = bus.latealu_enable && (bus.latealu_op == OP_MFC0);
    assign w_is_mtc0    = bus.latealu_enable && (bus.latealu_op == OP_MTC0);
    assign w_cp0_idx    = bus.latealu_a0[4:0];

`ifdef LATEALU_FAST_MULT_EN
    assign w_hilo_wr  = w_is_mult;
    assign w_hilo_val = {{32{bus.latealu_a0[31]}}, bus.latealu_a0} *
                        {{32{bus.latealu_a1[31]}}, bus.latealu_a1};
    assign mult_busy  = 1'b0;
`else
    localparam int unsigned STEPS = 32 / MULT_BITS_PER_CYCLE;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t      r_state, w_state_nxt;
    logic [63:0] r_mcand, r_acc, w_acc_nxt;
    logic [31:0] r_mplier;
    logic        r_sign;
    logic [5:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A new mult restarts and mthi/mtlo cancel; both take precedence over completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_is_mult) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_is_mthi || w_is_mtlo)  w_state_nxt = S_IDLE;
                else if (w_is_mult)          w_state_nxt = S_RUN;
                else if (r_cnt == 6'd1)      w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mult_busy = (r_state == S_RUN);
    end

    always_comb begin
        w_acc_nxt = r_acc;
        for (int unsigned i = 0; i < MULT_BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) w_acc_nxt = w_acc_nxt + (r_mcand << i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_is_mult) begin
            r_mcand  <= {32'd0, bus.latealu_a0[31] ? -bus.latealu_a0 : bus.latealu_a0};
            r_mplier <= bus.latealu_a1[31] ? -bus.latealu_a1 : bus.latealu_a1;
            r_sign   <= bus.latealu_a0[31] ^ bus.latealu_a1[31];
            r_acc    <= '0;
            r_cnt    <= 6'(STEPS);
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MULT_BITS_PER_CYCLE;
            r_mplier <= r_mplier >> MULT_BITS_PER_CYCLE;
            r_cnt    <= r_cnt - 6'd1;
        end
    end

    assign w_hilo_wr  = (r_state == S_RUN) && !w_is_mult && !w_is_mthi && !w_is_mtlo &&
                        (r_cnt == 6'd1);
    assign w_hilo_val = r_sign ? -w_acc_nxt : w_acc_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_is_mthi) begin
            r_hi <= bus.latealu_a0;
        end else if (w_is_mtlo) begin
            r_lo <= bus.latealu_a0;
        end else if (w_hilo_wr) begin
            {r_hi, r_lo} <= w_hilo_val;
        end
    end

    // An incoming exception overrides any CP0-writing op in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
            r_cause  <= '0;
            r_epc    <= '0;
        end else if (bus.exception_in != 3'd0) begin
            r_epc        <= bus.exception_pc;
            r_cause[6:2] <= (bus.exception_in == 3'd2) ? 5'd12 : 5'd10;
            r_status[1]  <= 1'b1;
        end else if (w_is_syscall) begin
            r_epc        <= bus.latealu_a0;
            r_cause[6:2] <= 5'd8;
            r_status[1]  <= 1'b1;
        end else if (w_is_eret) begin
            r_status[1]  <= 1'b0;
        end else if (w_is_mtc0) begin
            case (w_cp0_idx)
                5'd12:   r_status <= bus.latealu_a1;
                5'd13:   r_cause  <= bus.latealu_a1;
                5'd14:   r_epc    <= bus.latealu_a1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_cp0_idx)
            5'd12:   w_cp0_rd = r_status;
            5'd13:   w_cp0_rd = r_cause;
            5'd14:   w_cp0_rd = r_epc;
            default: w_cp0_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mfc0_valid <= 1'b0;
            mfc0_value <= '0;
        end else begin
            mfc0_valid <= w_is_mfc0;
            if (w_is_mfc0) mfc0_value <= w_cp0_rd;
        end
    end

    assign latealu_mult_hi = r_hi;
    assign latealu_mult_lo = r_lo;
    assign latealu_cpr14   = r_epc;
    assign exc_pending     = r_status[1];
endmodule

// File: tb/tb_pipeline_latealu.sv
// Randomized self-checking bench for pipeline_latealu against a cycle-level reference model.
module tb_pipeline_latealu;
    localparam int unsigned BPC = 1;
    localparam logic [5:0] OP_MULT = 6'b000100, OP_MTHI = 6'b000101, OP_MTLO = 6'b000110,
                           OP_SYSCALL = 6'b001000, OP_ERET = 6'b001001,
                           OP_MFC0 = 6'b001010, OP_MTC0 = 6'b001011;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] hi, lo, epc, mfc0_value;
    logic        busy, mfc0_valid, exc_pending;

    always #5 clk = ~clk;

    pipeline_latealu_if bus();

    pipeline_latealu #(.MULT_BITS_PER_CYCLE(BPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .latealu_mult_hi (hi),
        .latealu_mult_lo (lo),
        .latealu_cpr14   (epc),
        .mult_busy       (busy),
        .mfc0_valid      (mfc0_valid),
        .mfc0_value      (mfc0_value),
        .exc_pending     (exc_pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_hi, m_lo, m_status, m_cause, m_epc, m_mfc0_val;
    logic        m_mfc0_vld;
    int          m_left;
    logic [63:0] m_prod;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] cp0_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic       en;
        logic [5:0] op;
        longint     p;
        en = bus.latealu_enable;
        op = bus.latealu_op;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_status = 0; m_cause = 0; m_epc = 0;
            m_mfc0_val = 0; m_mfc0_vld = 0; m_left = 0; m_prod = 0;
            return;
        end
        m_mfc0_vld = en && op == OP_MFC0;
        if (m_mfc0_vld) m_mfc0_val = cp0_read(bus.latealu_a0[4:0]);
        if (en && op == OP_MULT) begin
            p = longint'($signed(bus.latealu_a0)) * longint'($signed(bus.latealu_a1));
`ifdef LATEALU_FAST_MULT_EN
            {m_hi, m_lo} = p;
            m_left = 0;
`else
            m_prod = p;
            m_left = 32 / BPC;
`endif
        end else if (en && (op == OP_MTHI || op == OP_MTLO)) begin
            m_left = 0;
            if (op == OP_MTHI) m_hi = bus.latealu_a0;
            else               m_lo = bus.latealu_a0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_prod;
        end
        if (bus.exception_in != 0) begin
            m_epc = bus.exception_pc;
            m_cause[6:2] = (bus.exception_in == 3'd2) ? 5'd12 : 5'd10;
            m_status[1] = 1'b1;
        end else if (en && op == OP_SYSCALL) begin
            m_epc = bus.latealu_a0;
            m_cause[6:2] = 5'd8;
            m_status[1] = 1'b1;
        end else if (en && op == OP_ERET) begin
            m_status[1] = 1'b0;
        end else if (en && op == OP_MTC0) begin
            case (bus.latealu_a0[4:0])
                5'd12: m_status = bus.latealu_a1;
                5'd13: m_cause  = bus.latealu_a1;
                5'd14: m_epc    = bus.latealu_a1;
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("epc", epc, m_epc);
        chk("busy", busy, m_left > 0);
        chk("mfc0_valid", mfc0_valid, m_mfc0_vld);
        chk("mfc0_value", mfc0_value, m_mfc0_val);
        chk("exc_pending", exc_pending, m_status[1]);
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [2:0] exc, input logic [31:0] pc);
        bus.latealu_enable = en;
        bus.latealu_op     = op;
        bus.latealu_a0     = a0;
        bus.latealu_a1     = a1;
        bus.exception_in   = exc;
        bus.exception_pc   = pc;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic op1(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1);
        drive(1'b1, op, a0, a1, 3'd0, 32'd0);
        tick();
        idle();
    endtask

    task automatic mfc0_expect(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        op1(OP_MFC0, {27'd0, idx}, 32'd0);
        chk({tag, "_vld"}, mfc0_valid, 1'b1);
        chk(tag, mfc0_value, exp);
        tick();
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int r;
        logic [31:0] a0, a1;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // 7 * -3
        op1(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
`ifdef LATEALU_FAST_MULT_EN
        chk("busy_len", n, 0);
`else
        chk("busy_len", n, 32 / BPC);
`endif
        chk("m73_hi", hi, 32'hFFFF_FFFF);
        chk("m73_lo", lo, 32'hFFFF_FFEB);

        // Most-negative squared, run to completion
        op1(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 40; i++) tick();
        chk("mneg_hi", hi, 32'h4000_0000);
        chk("mneg_lo", lo, 32'h0000_0000);

        // Cancel an in-flight multiply with mthi 5 cycles after it
        op1(OP_MTLO, 32'd0, 32'd0);
        op1(OP_MTHI, 32'd0, 32'd0);
        op1(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) tick();
        op1(OP_MTHI, 32'h1234, 32'd0);
        chk("cancel_hi", hi, 32'h1234);
        chk("cancel_lo", lo, 32'h0);
        chk("cancel_busy", busy, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        chk("cancel_hi_late", hi, 32'h1234);

        op1(OP_SYSCALL, 32'h0040_0020, 32'd0);
        chk("sys_epc", epc, 32'h0040_0020);
        mfc0_expect("sys_cause", 5'd13, 32'h20);
        mfc0_expect("sys_status", 5'd12, 32'h2);
        op1(OP_ERET, 32'd0, 32'd0);
        mfc0_expect("eret_status", 5'd12, 32'h0);
        mfc0_expect("eret_epc", 5'd14, 32'h0040_0020);

        op1(OP_MTC0, 32'd14, 32'hBFC0_0180);
        mfc0_expect("mtc0_epc", 5'd14, 32'hBFC0_0180);
        mfc0_expect("mfc0_idx9", 5'd9, 32'h0);

        drive(1'b1, OP_SYSCALL, 32'h200, 32'd0, 3'd2, 32'h100);
        tick();
        idle();
        chk("exc_epc", epc, 32'h100);
        mfc0_expect("exc_cause", 5'd13, 32'h30);

        // Reset during a multiply
        op1(OP_MTC0, 32'd12, 32'hFFFF_FFFF);
        op1(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        chk("rstmid_busy", busy, 1'b0);
        mfc0_expect("rstmid_status", 5'd12, 32'd0);
        mfc0_expect("rstmid_cause", 5'd13, 32'd0);
        mfc0_expect("rstmid_epc", 5'd14, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 29);
            a1 = rand_val();
            case ($urandom_range(0, 3))
                0: a0 = 32'd12;
                1: a0 = 32'd13;
                2: a0 = 32'd14;
                default: a0 = rand_val();
            endcase
            if (r <= 16) begin
                idle();
            end else begin
                case (r)
                    17, 18:  drive(1'b1, OP_MULT, rand_val(), a1, 3'd0, 32'd0);
                    19:      drive(1'b1, OP_MTHI, rand_val(), a1, 3'd0, 32'd0);
                    20:      drive(1'b1, OP_MTLO, rand_val(), a1, 3'd0, 32'd0);
                    21:      drive(1'b1, OP_SYSCALL, $urandom, a1, 3'd0, 32'd0);
                    22:      drive(1'b1, OP_ERET, a0, a1, 3'd0, 32'd0);
                    23, 24:  drive(1'b1, OP_MFC0, a0, a1, 3'd0, 32'd0);
                    25, 26:  drive(1'b1, OP_MTC0, a0, a1, 3'd0, 32'd0);
                    27:      drive(1'b1, 6'b111111, a0, a1, 3'd0, 32'd0);
                    default: drive(1'b1, OP_SYSCALL, a0, a1, 3'($urandom_range(1, 7)), $urandom);
                endcase
            end
            tick();
        end
        idle();
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_latealu.md
Name: pipeline_latealu

Overview:
Late-ALU stage, directly downstream of the ALU stage. Consumes the ALU stage's late-op request (enable/op/a0/a1) and exception code. Owns the HI/LO multiply state, with an iterative signed multiplier, and the CP0 registers Status(12), Cause(13) and EPC(14). Feeds HI/LO and EPC back to the ALU stage, and raises a stall while a multiply is in flight.

Parameters:
MULT_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; legal values 1/2/4/8; multiply latency = 32/MULT_BITS_PER_CYCLE cycles.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
latealu_enable  in  1  late-op request valid this cycle
latealu_op  in  6  000100 mult, 000101 mthi, 000110 mtlo, 001000 syscall, 001001 eret, 001010 mfc0, 001011 mtc0
latealu_a0  in  32  operand 0 (mult rs / mthi-mtlo value / syscall PC / CP0 index in [4:0])
latealu_a1  in  32  operand 1 (mult rt / mtc0 value)
exception_in  in  3  ALU exception code: 0 none, 1 reserved instruction, 2 overflow
exception_pc  in  32  PC of the faulting instruction
latealu_mult_hi  out  32  HI
latealu_mult_lo  out  32  LO
latealu_cpr14  out  32  EPC
mult_busy  out  1  multiply in flight; upstream holds mfhi/mflo while high
mfc0_valid  out  1  one-cycle pulse, mfc0 result ready
mfc0_value  out  32  mfc0 result
exc_pending  out  1  Status.EXL

Behaviour:
- Reset: all outputs 0; HI, LO, Status, Cause and EPC all 0; multiplier FSM in IDLE. Reset mid-multiply aborts it, with no HI/LO write.
- Multiplier FSM: IDLE -> RUN -> IDLE.
  - mult accepted in IDLE: latch |a0|, |a1| and sign = a0[31]^a1[31]; clear the 64-bit accumulator; load counter = 32/MULT_BITS_PER_CYCLE; mult_busy=1 from the next cycle.
  - RUN: each cycle, add MULT_BITS_PER_CYCLE partial products and decrement the counter.
  - Counter reaching 0: {HI,LO} <= sign ? -acc : acc, and the FSM returns to IDLE. HI/LO update and mult_busy drop in the same cycle.
  - Signed semantics: 0x80000000 * 0x80000000 = HI 0x40000000, LO 0x00000000.
- mult/mthi/mtlo arriving while RUN cancels the in-flight multiply, which never writes HI/LO.
  - mult: restarts with the new operands.
  - mthi/mtlo: write the named register next cycle; the other register keeps its pre-multiply value.
- mthi/mtlo in IDLE: HI (resp. LO) <= a0 at the next edge.
- mfc0: the index is a0[4:0]. mfc0_value is registered, and mfc0_valid pulses 1 cycle after the request.
  - Index 12/13/14 returns Status/Cause/EPC; any other index returns 0.
  - mfc0_value holds between pulses.
- mtc0: the index is a0[4:0]; Status/Cause/EPC are written with a1 at the next edge. Writes to any other index are ignored.
- syscall: EPC <= a0; Cause[6:2] <= 8; Status[1] <= 1.
- eret: Status[1] <= 0. EPC is unchanged.
- exception_in != 0: EPC <= exception_pc; Cause[6:2] <= 10 (code 1) or 12 (code 2); Status[1] <= 1. Codes 3..7 are treated as 1.
- Same-cycle priority: exception_in beats syscall/eret/mtc0; those CP0 ops are dropped that cycle. Multiplier ops and mfc0 are unaffected by exception_in.
- mtc0 to CP0 index 14 in the same cycle as syscall is impossible (single op per cycle); there is no other write conflict.
- CP0 ops execute in any multiplier state. latealu_enable=0 changes nothing except the multiplier progressing.

Optional Feature:
LATEALU_FAST_MULT_EN
- Defined: the multiply is a single-cycle signed 32x32; HI/LO are written at the edge after acceptance; mult_busy is tied to 0; MULT_BITS_PER_CYCLE is ignored.
- Undefined: the iterative FSM above is used.

Test Plan:
- Reset, then mult a0=7 a1=-3 with MULT_BITS_PER_CYCLE=1 -> mult_busy high for 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy low in the same cycle.
- mult 0x80000000*0x80000000, then mthi 0x1234 issued 5 cycles later -> no multiply result; HI=0x1234, LO=0, busy low next cycle.
- syscall a0=0x00400020 -> EPC=0x00400020, Cause=0x20, Status=0x2; then eret -> Status=0, EPC unchanged.
- mtc0 idx 14 a1=0xBFC00180, then mfc0 idx 14 -> mfc0_valid pulses 1 cycle later with 0xBFC00180; mfc0 idx 9 -> 0.
- exception_in=2, exception_pc=0x100, with syscall a0=0x200 in the same cycle -> EPC=0x100, Cause=0x30.
- Assert rst 10 cycles into a multiply -> next cycle HI=LO=0, mult_busy=0, CP0 regs all 0.
